// File: rtl/muldiv9900_pkg.sv
// ----------------------------------------------------------------------------
// muldiv9900_pkg
// Shared definitions for the TMS9900 sequential multiply/divide unit:
// opcode encodings, FSM state type, iteration count and datapath widths.
// ----------------------------------------------------------------------------
package muldiv9900_pkg;

    localparam int W          = 16;   // operand word width
    localparam int ITERATIONS = 16;   // shift/add or shift/subtract steps per op
    localparam int CNT_W      = 5;    // wide enough to hold ITERATIONS

    localparam logic OP_MPY = 1'b0;
    localparam logic OP_DIV = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage : muldiv9900_pkg

// File: rtl/muldiv9900_step.sv
// ----------------------------------------------------------------------------
// muldiv9900_step
// One combinational iteration of the multiply/divide datapath.
//   MPY: unsigned shift-add.  i_acc is the 17-bit accumulator, i_mpr the
//        multiplier (product low bits shift in from the top), i_operand the
//        multiplicand.
//   DIV: unsigned restoring.  i_acc is the 17-bit partial remainder, i_mpr
//        holds the remaining dividend bits (quotient bits shift in at the
//        bottom), i_operand the divisor.
// Ports:
//   i_op       0 = MPY, 1 = DIV
//   i_acc      accumulator / partial remainder in
//   i_mpr      multiplier / dividend-quotient in
//   i_operand  multiplicand (MPY) or divisor (DIV)
//   o_acc      next accumulator / partial remainder
//   o_mpr      next multiplier / dividend-quotient
// ----------------------------------------------------------------------------
module muldiv9900_step
    import muldiv9900_pkg::*;
(
    input  logic         i_op,
    input  logic [W:0]   i_acc,
    input  logic [W-1:0] i_mpr,
    input  logic [W-1:0] i_operand,
    output logic [W:0]   o_acc,
    output logic [W-1:0] o_mpr
);

    logic [W:0] w_addend;
    logic [W:0] w_sum;
    logic [W:0] w_shifted;
    logic [W:0] w_diff;
    logic       w_ge;

    always_comb begin
        // NOTE: every output of a combinational block gets a value on every
        // path; assigning defaults first guarantees no latch is inferred.
        o_acc = '0;
        o_mpr = '0;

        // Multiply: add multiplicand when the multiplier LSB is set.
        w_addend = i_mpr[0] ? {1'b0, i_operand} : '0;
        w_sum    = i_acc + w_addend;

        // Divide: shift the next dividend bit into the partial remainder.
        // The remainder stays below the divisor, so 17 bits never overflow.
        w_shifted = {i_acc[W-1:0], i_mpr[W-1]};
        w_ge      = (w_shifted >= {1'b0, i_operand});
        w_diff    = w_shifted - {1'b0, i_operand};

        if (i_op == OP_MPY) begin
            o_acc = {1'b0, w_sum[W:1]};
            o_mpr = {w_sum[0], i_mpr[W-1:1]};
        end else begin
            o_acc = w_ge ? w_diff : w_shifted;
            o_mpr = {i_mpr[W-2:0], w_ge};
        end
    end

endmodule : muldiv9900_step

// File: rtl/muldiv9900.sv
// ----------------------------------------------------------------------------
// muldiv9900
// Sequential MPY/DIV unit beside the TMS9900 ALU. The sequencer loads
// operands, pulses start, waits for done, then writes result_hi to D,
// result_lo to D+1 and overflow to ST4.
// Latency is 16/STEPS_PER_CLK cycles (legal STEPS_PER_CLK: 1, 2, 4);
// a DIV whose divisor is not above the dividend high word completes at once
// with overflow set.
// Ports:
//   clk        system clock, rising edge
//   reset      asynchronous, active-high reset
//   start      request, sampled only in IDLE
//   op         0 = MPY, 1 = DIV
//   src        multiplier or divisor
//   dst_hi     multiplicand or dividend high word
//   dst_lo     dividend low word (ignored for MPY)
//   busy       high whenever the FSM is not IDLE
//   done       one-cycle pulse, results valid
//   result_hi  MPY product[31:16] / DIV quotient
//   result_lo  MPY product[15:0]  / DIV remainder
//   overflow   DIV overflow, always 0 for MPY
// ----------------------------------------------------------------------------
module muldiv9900
    import muldiv9900_pkg::*;
#(
    parameter int STEPS_PER_CLK = 1
)(
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic         op,
    input  logic [W-1:0] src,
    input  logic [W-1:0] dst_hi,
    input  logic [W-1:0] dst_lo,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] result_hi,
    output logic [W-1:0] result_lo,
    output logic         overflow
);

    state_t             r_state;
    logic               r_op;
    logic [W-1:0]       r_operand;
    logic [W:0]         r_acc;
    logic [W-1:0]       r_mpr;
    logic [CNT_W-1:0]   r_count;
    logic               r_busy;
    logic               r_done;
    logic               r_overflow;
    logic [W-1:0]       r_result_hi;
    logic [W-1:0]       r_result_lo;

    logic [W:0]         w_acc_chain [STEPS_PER_CLK+1];
    logic [W-1:0]       w_mpr_chain [STEPS_PER_CLK+1];
    logic [CNT_W-1:0]   w_count_next;
    logic [W:0]         w_acc_final;
    logic [W-1:0]       w_mpr_final;

    // Chain of STEPS_PER_CLK iterations evaluated within one clock.
    assign w_acc_chain[0] = r_acc;
    assign w_mpr_chain[0] = r_mpr;

    for (genvar g = 0; g < STEPS_PER_CLK; g++) begin : g_step
        muldiv9900_step u_step (
            .i_op      (r_op),
            .i_acc     (w_acc_chain[g]),
            .i_mpr     (w_mpr_chain[g]),
            .i_operand (r_operand),
            .o_acc     (w_acc_chain[g+1]),
            .o_mpr     (w_mpr_chain[g+1])
        );
    end

    assign w_acc_final  = w_acc_chain[STEPS_PER_CLK];
    assign w_mpr_final  = w_mpr_chain[STEPS_PER_CLK];
    assign w_count_next = r_count + CNT_W'(STEPS_PER_CLK);

    always_ff @(posedge clk or posedge reset) begin
        // NOTE: the working registers are reset along with the control state
        // so a reset mid-operation leaves no stale partial result behind.
        if (reset) begin
            r_state     <= ST_IDLE;
            r_op        <= OP_MPY;
            r_operand   <= '0;
            r_acc       <= '0;
            r_mpr       <= '0;
            r_count     <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_overflow  <= 1'b0;
            r_result_hi <= '0;
            r_result_lo <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register samples the values from before this edge.
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_op       <= op;
                        r_overflow <= 1'b0;
                        r_count    <= '0;
                        r_busy     <= 1'b1;
                        // Quotient would not fit in 16 bits (or divisor is 0):
                        // flag overflow and pass the dividend through.
                        if (op == OP_DIV && src <= dst_hi) begin
                            r_overflow  <= 1'b1;
                            r_result_hi <= dst_hi;
                            r_result_lo <= dst_lo;
                            r_done      <= 1'b1;
                            r_state     <= ST_DONE;
                        end else begin
                            r_operand <= (op == OP_DIV) ? src : dst_hi;
                            r_acc     <= (op == OP_DIV) ? {1'b0, dst_hi} : '0;
                            r_mpr     <= (op == OP_DIV) ? dst_lo : src;
                            r_state   <= ST_RUN;
                        end
                    end
                end

                ST_RUN: begin
                    r_acc   <= w_acc_final;
                    r_mpr   <= w_mpr_final;
                    r_count <= w_count_next;
                    if (w_count_next == CNT_W'(ITERATIONS)) begin
                        r_done  <= 1'b1;
                        r_state <= ST_DONE;
                        if (r_op == OP_DIV) begin
                            r_result_hi <= w_mpr_final;          // quotient
                            r_result_lo <= w_acc_final[W-1:0];   // remainder
                        end else begin
                            r_result_hi <= w_acc_final[W-1:0];
                            r_result_lo <= w_mpr_final;
                        end
                    end
                end

                ST_DONE: begin
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end

                default: begin
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy      = r_busy;
    assign done      = r_done;
    assign result_hi = r_result_hi;
    assign result_lo = r_result_lo;
    assign overflow  = r_overflow;

endmodule : muldiv9900

// File: tb/tb_muldiv9900.sv
// ----------------------------------------------------------------------------
// tb_muldiv9900
// Directed bench for muldiv9900 with hand-computed expected values.
// Two instances: STEPS_PER_CLK=1 and STEPS_PER_CLK=4.
// Inputs are driven and outputs sampled on the falling clock edge.
// ----------------------------------------------------------------------------
module tb_muldiv9900;

    logic        clk = 1'b0;
    logic        reset;
    logic        start1;
    logic        start4;
    logic        op;
    logic [15:0] src;
    logic [15:0] dst_hi;
    logic [15:0] dst_lo;

    logic        busy1, done1, ovf1;
    logic [15:0] hi1, lo1;
    logic        busy4, done4, ovf4;
    logic [15:0] hi4, lo4;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    muldiv9900 #(.STEPS_PER_CLK(1)) dut1 (
        .clk       (clk),
        .reset     (reset),
        .start     (start1),
        .op        (op),
        .src       (src),
        .dst_hi    (dst_hi),
        .dst_lo    (dst_lo),
        .busy      (busy1),
        .done      (done1),
        .result_hi (hi1),
        .result_lo (lo1),
        .overflow  (ovf1)
    );

    muldiv9900 #(.STEPS_PER_CLK(4)) dut4 (
        .clk       (clk),
        .reset     (reset),
        .start     (start4),
        .op        (op),
        .src       (src),
        .dst_hi    (dst_hi),
        .dst_lo    (dst_lo),
        .busy      (busy4),
        .done      (done4),
        .result_hi (hi4),
        .result_lo (lo4),
        .overflow  (ovf4)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Issue one operation and follow it until busy drops.
    // Sample index k counts falling edges after the start edge E0 (k=0 is
    // the cycle right after E0). If restart_k >= 0, start is re-asserted with
    // different operands while the unit is busy.
    task automatic run_op(input bit use4, input string tag, input logic opv,
                          input logic [15:0] s, input logic [15:0] h, input logic [15:0] l,
                          input int exp_lat, input logic [15:0] exp_hi,
                          input logic [15:0] exp_lo, input logic exp_ovf,
                          input int restart_k);
        int   done_at;
        int   n_busy;
        int   n_done;
        logic b, d;
        done_at = -1;
        n_busy  = 0;
        n_done  = 0;
        @(negedge clk);
        op = opv; src = s; dst_hi = h; dst_lo = l;
        if (use4) start4 = 1'b1; else start1 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start1 = 1'b0; start4 = 1'b0;
        // Operands changing after the start edge must have no effect.
        src = ~s; dst_hi = ~h; dst_lo = ~l; op = ~opv;
        for (int k = 0; k < 64; k++) begin
            b = use4 ? busy4 : busy1;
            d = use4 ? done4 : done1;
            if (b) n_busy++;
            if (d) begin
                n_done++;
                if (done_at < 0) done_at = k;
            end
            if (!b) break;
            if (k == restart_k) begin
                op = 1'b1; src = 16'h0001; dst_hi = 16'h0000; dst_lo = 16'h0042;
                if (use4) start4 = 1'b1; else start1 = 1'b1;
            end else begin
                start1 = 1'b0; start4 = 1'b0;
            end
            @(negedge clk);
        end
        start1 = 1'b0; start4 = 1'b0;
        check({tag, "_latency"},   done_at, exp_lat);
        check({tag, "_busy_cyc"},  n_busy,  exp_lat + 1);
        check({tag, "_done_cnt"},  n_done,  1);
        check({tag, "_hi"},        use4 ? hi4 : hi1,   exp_hi);
        check({tag, "_lo"},        use4 ? lo4 : lo1,   exp_lo);
        check({tag, "_overflow"},  use4 ? ovf4 : ovf1, exp_ovf);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int seen_done;
        reset = 1'b1; start1 = 1'b0; start4 = 1'b0;
        op = 1'b0; src = '0; dst_hi = '0; dst_lo = '0;
        repeat (3) @(negedge clk);
        check("rst_busy", busy1, 0);
        check("rst_done", done1, 0);
        check("rst_hi",   hi1,   0);
        check("rst_lo",   lo1,   0);
        check("rst_ovf",  ovf1,  0);
        check("rst_busy4", busy4, 0);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        // 0x1234 * 0x5678 = 0x0626_0060
        run_op(0, "mpy_basic", 1'b0, 16'h5678, 16'h1234, 16'h0000, 16, 16'h0626, 16'h0060, 1'b0, -1);
        // 0xFFFF * 0xFFFF = 0xFFFE_0001
        run_op(0, "mpy_max",   1'b0, 16'hFFFF, 16'hFFFF, 16'h0000, 16, 16'hFFFE, 16'h0001, 1'b0, -1);
        // 0x0000 * 0xABCD = 0
        run_op(0, "mpy_zero",  1'b0, 16'h0000, 16'hABCD, 16'h0000, 16, 16'h0000, 16'h0000, 1'b0, -1);
        // 0x0001_0000 / 3 = 0x5555 rem 1
        run_op(0, "div_basic", 1'b1, 16'h0003, 16'h0001, 16'h0000, 16, 16'h5555, 16'h0001, 1'b0, -1);
        // 100 / 7 = 14 rem 2
        run_op(0, "div_small", 1'b1, 16'h0007, 16'h0000, 16'h0064, 16, 16'h000E, 16'h0002, 1'b0, -1);
        // divisor equal to dividend high word: overflow, dividend passes through
        run_op(0, "div_ovf",   1'b1, 16'h0002, 16'h0002, 16'h1234, 0,  16'h0002, 16'h1234, 1'b1, -1);
        // divide by zero behaves as overflow
        run_op(0, "div_zero",  1'b1, 16'h0000, 16'h00AB, 16'h5555, 0,  16'h00AB, 16'h5555, 1'b1, -1);
        // MPY after an overflow clears the flag: 3 * 7 = 21
        run_op(0, "mpy_clr",   1'b0, 16'h0003, 16'h0007, 16'h0000, 16, 16'h0000, 16'h0015, 1'b0, -1);
        // start re-asserted mid-run is ignored
        run_op(0, "mpy_restart", 1'b0, 16'h5678, 16'h1234, 16'h0000, 16, 16'h0626, 16'h0060, 1'b0, 5);

        // Reset in the middle of a run (after 8 iterations).
        @(negedge clk);
        op = 1'b0; src = 16'hFFFF; dst_hi = 16'hFFFF; start1 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start1 = 1'b0;
        repeat (8) @(negedge clk);
        check("mid_busy_before", busy1, 1);
        #2 reset = 1'b1;
        #1;
        check("mid_rst_busy", busy1, 0);
        check("mid_rst_done", done1, 0);
        check("mid_rst_hi",   hi1,   0);
        check("mid_rst_lo",   lo1,   0);
        @(negedge clk);
        reset = 1'b0;
        seen_done = 0;
        for (int k = 0; k < 24; k++) begin
            @(negedge clk);
            if (done1 || busy1) seen_done++;
        end
        check("mid_rst_no_done", seen_done, 0);

        // Four iterations per clock.
        // 0xFFFE_FFFE = 0xFFFF * 0xFFFF + 0xFFFD
        run_op(1, "div4",     1'b1, 16'hFFFF, 16'hFFFE, 16'hFFFE, 4, 16'hFFFF, 16'hFFFD, 1'b0, -1);
        run_op(1, "mpy4",     1'b0, 16'h5678, 16'h1234, 16'h0000, 4, 16'h0626, 16'h0060, 1'b0, -1);
        // 0xFFFF_FFFE / 0xFFFF: high word equals divisor -> overflow
        run_op(1, "div4_ovf", 1'b1, 16'hFFFF, 16'hFFFF, 16'hFFFE, 0, 16'hFFFF, 16'hFFFE, 1'b1, -1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule : tb_muldiv9900
